// File: rtl/ae_cmd_pkg.sv
// rtl/ae_cmd_pkg.sv - shared constants, FSM encoding and legality helper for ae_cmd_rx
package ae_cmd_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_START = 8'h02;
   localparam logic [7:0] OP_STOP  = 8'h03;

   localparam logic [7:0] REG_DECIM = 8'd0;
   localparam logic [7:0] REG_CHEN  = 8'd1;
   localparam logic [7:0] REG_TH1   = 8'd2;
   localparam logic [7:0] REG_TH2   = 8'd3;

   localparam int SYNC_HI = 31;
   localparam int SYNC_LO = 24;
   localparam int OP_HI   = 23;
   localparam int OP_LO   = 16;
   localparam int ADDR_HI = 15;
   localparam int ADDR_LO = 8;
   localparam int LEN_HI  = 7;
   localparam int LEN_LO  = 0;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_PAYLOAD,
      ST_CHECK,
      ST_EXEC,
      ST_ERR
   } cmd_state_t;

   // Opcode/addr/len combinations that may change configuration.
   function automatic logic cmd_legal(input logic [7:0] op, input logic [7:0] addr,
                                      input logic [7:0] len);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_WRITE:          ok = (len == 8'd1) && (addr <= REG_TH2);
         OP_START, OP_STOP: ok = (len == 8'd0);
         default:           ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ae_cmd_rx_if.sv
// rtl/ae_cmd_rx_if.sv - command FIFO read port (master = reader, slave = FIFO)
interface ae_cmd_rx_if #(parameter int DATA_W = 32);
   logic              fifo_rd_en;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_empty;

   modport master (output fifo_rd_en, input fifo_dout, input fifo_empty);
   modport slave  (input fifo_rd_en, output fifo_dout, output fifo_empty);
endinterface

// File: rtl/ae_cmd_fetch.sv
// rtl/ae_cmd_fetch.sv - single-outstanding FIFO read engine feeding the parser one word at a time
module ae_cmd_fetch (
   input  logic          bus_clk,
   input  logic          RESET,
   input  logic          wr_open,
   input  logic          need,
   ae_cmd_rx_if.master   fifo,
   output logic          word_valid,
   output logic [31:0]   word
);

   logic rd_pending;

   // fifo_dout is valid the cycle after the strobe, so a pending read blocks the next one.
   always_comb begin
      fifo.fifo_rd_en = !RESET && wr_open && need && !fifo.fifo_empty && !rd_pending;
   end

   always_ff @(posedge bus_clk) begin
      if (RESET) begin
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= fifo.fifo_rd_en;
      end
   end

   assign word_valid = rd_pending && wr_open;
   assign word       = fifo.fifo_dout;

endmodule

// File: rtl/ae_cmd_rx.sv
// rtl/ae_cmd_rx.sv - command packet parser driving acquisition config; AE_CMD_CHECKSUM_EN adds XOR check word
module ae_cmd_rx
   import ae_cmd_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          MAX_LEN   = 4,
   parameter logic [15:0] DECIM_RST = 16'd1,
   parameter int          ERR_W     = 8
) (
   input  logic             bus_clk,
   input  logic             RESET,
   input  logic             wr_open,
   ae_cmd_rx_if.master      fifo,
   output logic             acq_run,
   output logic [15:0]      decim,
   output logic [1:0]       ch_enable,
   output logic [13:0]      thresh1,
   output logic [13:0]      thresh2,
   output logic             cmd_ok,
   output logic             cmd_err,
   output logic [15:0]      cmd_count,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   cmd_state_t        state_q, state_d;
   logic              word_valid;
   logic [DATA_W-1:0] word;
   logic              need, do_exec, do_err;
   logic [7:0]        op_q, addr_q, len_q, cnt_q;
   logic [DATA_W-1:0] pay0_q;
   logic              hdr_ok, last_pay;
   cmd_state_t        hdr_done, pay_done;
`ifdef AE_CMD_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;
`endif

   ae_cmd_fetch u_fetch (
      .bus_clk    (bus_clk),
      .RESET      (RESET),
      .wr_open    (wr_open),
      .need       (need),
      .fifo       (fifo),
      .word_valid (word_valid),
      .word       (word)
   );

   assign hdr_ok   = (word[SYNC_HI:SYNC_LO] == SYNC_BYTE) && (word[LEN_HI:LEN_LO] <= MAX_LEN_B);
   assign last_pay = (cnt_q == len_q - 8'd1);

`ifdef AE_CMD_CHECKSUM_EN
   assign hdr_done = ST_CHECK;
   assign pay_done = ST_CHECK;
`else
   // Legality is resolved on the final word's edge so EXEC/ERR already encodes the outcome.
   assign hdr_done = cmd_legal(word[OP_HI:OP_LO], word[ADDR_HI:ADDR_LO], 8'd0) ? ST_EXEC : ST_ERR;
   assign pay_done = cmd_legal(op_q, addr_q, len_q) ? ST_EXEC : ST_ERR;
`endif

   always_ff @(posedge bus_clk) begin
      if (RESET) state_q <= ST_HUNT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HUNT:    if (word_valid && hdr_ok)
                        state_d = (word[LEN_HI:LEN_LO] == 8'd0) ? hdr_done : ST_PAYLOAD;
         ST_PAYLOAD: if (word_valid && last_pay) state_d = pay_done;
`ifdef AE_CMD_CHECKSUM_EN
         ST_CHECK:   if (word_valid)
                        state_d = (cmd_legal(op_q, addr_q, len_q) && (csum_q == word)) ? ST_EXEC : ST_ERR;
`endif
         default:    state_d = ST_HUNT;
      endcase
      if (!wr_open) state_d = ST_HUNT;
   end

   always_comb begin
      need    = (state_q == ST_HUNT) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
      do_exec = (state_q == ST_EXEC);
      do_err  = (state_q == ST_ERR) || ((state_q == ST_HUNT) && word_valid && !hdr_ok);
   end

   always_ff @(posedge bus_clk) begin
      if (RESET) begin
         op_q <= '0; addr_q <= '0; len_q <= '0; cnt_q <= '0; pay0_q <= '0;
`ifdef AE_CMD_CHECKSUM_EN
         csum_q <= '0;
`endif
         acq_run <= 1'b0; decim <= DECIM_RST; ch_enable <= 2'b11;
         thresh1 <= '0; thresh2 <= '0;
         cmd_ok <= 1'b0; cmd_err <= 1'b0; cmd_count <= '0; err_count <= '0;
      end else begin
         if ((state_q == ST_HUNT) && word_valid && hdr_ok) begin
            op_q   <= word[OP_HI:OP_LO];
            addr_q <= word[ADDR_HI:ADDR_LO];
            len_q  <= word[LEN_HI:LEN_LO];
            cnt_q  <= '0;
`ifdef AE_CMD_CHECKSUM_EN
            csum_q <= word;
`endif
         end
         if ((state_q == ST_PAYLOAD) && word_valid) begin
            if (cnt_q == 8'd0) pay0_q <= word;
            cnt_q <= cnt_q + 8'd1;
`ifdef AE_CMD_CHECKSUM_EN
            csum_q <= csum_q ^ word;
`endif
         end
         cmd_ok  <= do_exec;
         cmd_err <= do_err;
         if (do_exec) begin
            cmd_count <= cmd_count + 16'd1;
            case (op_q)
               OP_WRITE: case (addr_q)
                  REG_DECIM: decim     <= pay0_q[15:0];
                  REG_CHEN:  ch_enable <= pay0_q[1:0];
                  REG_TH1:   thresh1   <= pay0_q[13:0];
                  default:   thresh2   <= pay0_q[13:0];
               endcase
               OP_START: acq_run <= 1'b1;
               default:  acq_run <= 1'b0;
            endcase
         end
         if (do_err && (err_count != {ERR_W{1'b1}})) err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_ae_cmd_rx.sv
// tb/tb_ae_cmd_rx.sv - directed self-checking bench for ae_cmd_rx
module tb_ae_cmd_rx;
   logic        bus_clk = 1'b0;
   logic        RESET = 1'b1;
   logic        wr_open = 1'b0;
   logic        acq_run, cmd_ok, cmd_err;
   logic [15:0] decim, cmd_count;
   logic [1:0]  ch_enable;
   logic [13:0] thresh1, thresh2;
   logic [7:0]  err_count;

   int errors = 0, checks = 0;
   int ok_cnt = 0, err_cnt = 0, viol = 0, rd_count = 0, push_count = 0;
   int ok_base, err_base;
   logic stall = 1'b0, rand_en = 1'b0;
   logic [31:0] q[$];

   ae_cmd_rx_if fif ();

   ae_cmd_rx dut (
      .bus_clk(bus_clk), .RESET(RESET), .wr_open(wr_open), .fifo(fif),
      .acq_run(acq_run), .decim(decim), .ch_enable(ch_enable),
      .thresh1(thresh1), .thresh2(thresh2), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
      .cmd_count(cmd_count), .err_count(err_count)
   );

   always #5 bus_clk = ~bus_clk;

   assign fif.fifo_empty = (q.size() == 0) || stall;

   always @(posedge bus_clk) begin
      if (fif.fifo_rd_en) begin
         if (q.size() == 0) viol++;
         else begin
            fif.fifo_dout <= q.pop_front();
            rd_count++;
         end
      end
   end

   always @(negedge bus_clk) begin
      stall = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (fif.fifo_rd_en && (fif.fifo_empty || !wr_open)) viol++;
      if (!RESET && cmd_ok)  ok_cnt++;
      if (!RESET && cmd_err) err_cnt++;
   end

   task automatic push_word(input logic [31:0] w);
      q.push_back(w);
      push_count++;
   endtask

   task automatic pkt0(input logic [31:0] h);
      push_word(h);
`ifdef AE_CMD_CHECKSUM_EN
      push_word(h);
`endif
   endtask

   task automatic pkt1(input logic [31:0] h, input logic [31:0] p);
      push_word(h);
      push_word(p);
`ifdef AE_CMD_CHECKSUM_EN
      push_word(h ^ p);
`endif
   endtask

   task automatic wait_drain(input string name);
      int i;
      for (i = 0; i < 4000; i++) begin
         if (q.size() == 0) break;
         @(negedge bus_clk);
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d words left, want 0", name, q.size());
      end
      repeat (6) @(negedge bus_clk);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(negedge bus_clk);
      checks++;
      if ({acq_run, decim, ch_enable, thresh1, thresh2, cmd_count, err_count, fif.fifo_rd_en} !==
          {1'b0, 16'd1, 2'b11, 14'd0, 14'd0, 16'd0, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset: acq=%b decim=%h chen=%b th1=%h th2=%h cmd=%h err=%h rd=%b want 0 0001 11 0 0 0 0 0",
                  acq_run, decim, ch_enable, thresh1, thresh2, cmd_count, err_count, fif.fifo_rd_en);
      end
      RESET = 1'b0;
      wr_open = 1'b1;
      @(negedge bus_clk);
   endtask

   task automatic test_write_decim();
      ok_base = ok_cnt;
      pkt1(32'hA501_0001, 32'd10);
      wait_drain("write_decim");
      checks++;
      if (decim !== 16'd10) begin errors++; $display("FAIL write_decim: decim=%h want 000a", decim); end
      checks++;
      if (cmd_count !== 16'd1 || ok_cnt - ok_base != 1) begin
         errors++; $display("FAIL write_ok: cmd_count=%0d ok_pulses=%0d want 1 1", cmd_count, ok_cnt - ok_base);
      end
   endtask

   task automatic test_start_stop();
      pkt0(32'hA502_0000);
      wait_drain("start");
      checks++;
      if (acq_run !== 1'b1) begin errors++; $display("FAIL start: acq_run=%b want 1", acq_run); end
      pkt0(32'hA503_0000);
      wait_drain("stop");
      checks++;
      if (acq_run !== 1'b0 || cmd_count !== 16'd3) begin
         errors++; $display("FAIL stop: acq_run=%b cmd_count=%0d want 0 3", acq_run, cmd_count);
      end
   endtask

   task automatic test_garbage();
      err_base = err_cnt;
      push_word(32'h1234_5678);
      pkt1(32'hA501_0201, 32'h0000_1FFF);
      push_word(32'hA501_0005);
      wait_drain("garbage");
      checks++;
      if (thresh1 !== 14'h1FFF) begin errors++; $display("FAIL garbage_th1: thresh1=%h want 1fff", thresh1); end
      checks++;
      if (err_count !== 8'd2 || err_cnt - err_base != 2 || cmd_count !== 16'd4) begin
         errors++;
         $display("FAIL garbage_err: err_count=%0d pulses=%0d cmd_count=%0d want 2 2 4",
                  err_count, err_cnt - err_base, cmd_count);
      end
   endtask

   task automatic test_bad_cmd();
      pkt1(32'hA501_0701, 32'h0000_BEEF);
      pkt1(32'hA501_0301, 32'h0000_0123);
      pkt0(32'hA507_0000);
      pkt1(32'hA502_0001, 32'h0000_0000);
      wait_drain("bad_cmd");
      checks++;
      if (thresh2 !== 14'h0123 || thresh1 !== 14'h1FFF || decim !== 16'd10 || acq_run !== 1'b0) begin
         errors++;
         $display("FAIL bad_cmd_regs: th2=%h th1=%h decim=%h acq=%b want 0123 1fff 000a 0",
                  thresh2, thresh1, decim, acq_run);
      end
      checks++;
      if (err_count !== 8'd5 || cmd_count !== 16'd5) begin
         errors++; $display("FAIL bad_cmd_cnt: err=%0d cmd=%0d want 5 5", err_count, cmd_count);
      end
   endtask

   task automatic test_back_to_back();
      rand_en = 1'b1;
      pkt1(32'hA501_0001, 32'h0000_0042);
      pkt1(32'hA501_0101, 32'h0000_0002);
      pkt0(32'hA502_0000);
      pkt1(32'hA501_0201, 32'hFFFF_FFFF);
      wait_drain("b2b");
      rand_en = 1'b0;
      checks++;
      if (decim !== 16'h0042 || ch_enable !== 2'b10 || acq_run !== 1'b1 || thresh1 !== 14'h3FFF) begin
         errors++;
         $display("FAIL b2b_regs: decim=%h chen=%b acq=%b th1=%h want 0042 10 1 3fff",
                  decim, ch_enable, acq_run, thresh1);
      end
      checks++;
      if (cmd_count !== 16'd9 || err_count !== 8'd5 || rd_count != push_count) begin
         errors++;
         $display("FAIL b2b_cnt: cmd=%0d err=%0d reads=%0d pushed=%0d want 9 5 equal",
                  cmd_count, err_count, rd_count, push_count);
      end
   endtask

   task automatic test_wr_open();
      push_word(32'hA501_0001);
      wait_drain("wr_open_hdr");
      wr_open = 1'b0;
      pkt1(32'hA501_0001, 32'h0000_0007);
      repeat (4) @(negedge bus_clk);
      checks++;
      if (q.size() != (push_count - rd_count) || rd_count + q.size() != push_count || fif.fifo_rd_en !== 1'b0) begin
         errors++; $display("FAIL wr_open_hold: rd_en=%b queued=%0d", fif.fifo_rd_en, q.size());
      end
      wr_open = 1'b1;
      wait_drain("wr_open");
      checks++;
      if (decim !== 16'd7 || err_count !== 8'd5 || cmd_count !== 16'd10) begin
         errors++;
         $display("FAIL wr_open_drop: decim=%h err=%0d cmd=%0d want 0007 5 10", decim, err_count, cmd_count);
      end
   endtask

`ifdef AE_CMD_CHECKSUM_EN
   task automatic test_checksum();
      push_word(32'hA501_0001);
      push_word(32'h0000_0005);
      push_word(32'hDEAD_BEEF);
      wait_drain("checksum");
      checks++;
      if (decim !== 16'd7 || err_count !== 8'd6) begin
         errors++; $display("FAIL checksum: decim=%h err=%0d want 0007 6", decim, err_count);
      end
   endtask
`endif

   task automatic test_reset_mid();
      push_word(32'hA501_0001);
      wait_drain("reset_mid_hdr");
      RESET = 1'b1;
      @(negedge bus_clk);
      checks++;
      if ({acq_run, decim, ch_enable, thresh1, cmd_count, err_count} !==
          {1'b0, 16'd1, 2'b11, 14'd0, 16'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_mid: acq=%b decim=%h chen=%b th1=%h cmd=%0d err=%0d want 0 0001 11 0 0 0",
                  acq_run, decim, ch_enable, thresh1, cmd_count, err_count);
      end
      RESET = 1'b0;
      pkt1(32'hA501_0001, 32'h0000_0009);
      wait_drain("reset_mid");
      checks++;
      if (decim !== 16'd9 || cmd_count !== 16'd1 || err_count !== 8'd0) begin
         errors++; $display("FAIL reset_mid_next: decim=%h cmd=%0d err=%0d want 0009 1 0", decim, cmd_count, err_count);
      end
   endtask

   task automatic test_err_saturate();
      for (int i = 0; i < 300; i++) push_word(32'h0000_0000);
      wait_drain("saturate");
      checks++;
      if (err_count !== 8'hFF || cmd_count !== 16'd1) begin
         errors++; $display("FAIL err_saturate: err=%h cmd=%0d want ff 1", err_count, cmd_count);
      end
      checks++;
      if (viol != 0) begin errors++; $display("FAIL rd_en_rule: violations=%0d want 0", viol); end
   endtask

   initial begin
      test_reset();
      test_write_decim();
      test_start_stop();
      test_garbage();
      test_bad_cmd();
      test_back_to_back();
      test_wr_open();
`ifdef AE_CMD_CHECKSUM_EN
      test_checksum();
`endif
      test_reset_mid();
      test_err_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
